// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if
//   Bundles the processor data port and the memory read/write ports seen by
//   store_write_buffer.
//   slave  : the buffer's view (processor requests and memory responses in,
//            load data, stall, memory write channel and status out).
//   master : the view of whatever drives the processor side and models memory.
//   Signals:
//     cpu_we/cpu_addr/cpu_wdata  store request, byte address, store data
//     cpu_rdata/cpu_stall        load data (combinational), hold-PC indication
//     mem_raddr/mem_rdata        memory read address / combinational read data
//     mem_wvalid/mem_wready      write handshake for the head entry
//     mem_waddr/mem_wdata        head entry address / data
//     flush/flush_done/empty     drain request, one-cycle drain-complete, idle
interface store_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          flush;
    logic          flush_done;
    logic          empty;

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_wready, flush,
        output cpu_rdata, cpu_stall, mem_raddr, mem_wvalid, mem_waddr,
               mem_wdata, flush_done, empty
    );

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_wready, flush,
        input  cpu_rdata, cpu_stall, mem_raddr, mem_wvalid, mem_waddr,
               mem_wdata, flush_done, empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Absorbs processor stores into a DEPTH-entry FIFO and drains them in order
//   over a valid/ready memory write port. Loads return the youngest buffered
//   word with a matching word address, otherwise the memory read data. The
//   processor is stalled only when a store arrives while the buffer is full
//   or while a requested flush is draining.
//   Ports:
//     clk, rst   clock; asynchronous active-high reset
//     bus        store_write_buffer_if.slave (processor + memory ports)
//   Parameters: DEPTH (power of two, >=2), AW address width, DW data width.
//   Optional build macro WBUF_COALESCE_EN: a store to the same word as the
//   youngest entry overwrites that entry in place (only when at least two
//   entries are held, so the head that may be mid-handshake is never touched).
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    store_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic          full, is_empty, flushing;
    logic          enq, deq, coal;
    logic [PW-1:0] tail;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    assign full     = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign flushing = (state_q == FLUSH);
    assign tail     = wr_ptr_q - PW'(1);

`ifdef WBUF_COALESCE_EN
    assign coal = bus.cpu_we && !flushing && (count_q >= CW'(2)) &&
                  (addr_q[tail][AW-1:2] == bus.cpu_addr[AW-1:2]);
`else
    assign coal = 1'b0;
`endif

    assign enq = bus.cpu_we && !full && !flushing && !coal;
    assign deq = !is_empty && bus.mem_wready;

    // Stall uses the registered count only: a dequeue in the same cycle does
    // not free a slot for the waiting store until the next cycle.
    assign bus.cpu_stall  = bus.cpu_we && (flushing || (full && !coal));
    assign bus.mem_raddr  = bus.cpu_addr;
    assign bus.mem_wvalid = !is_empty;
    assign bus.mem_waddr  = addr_q[rd_ptr_q];
    assign bus.mem_wdata  = data_q[rd_ptr_q];
    assign bus.flush_done = (state_q == DONE);
    assign bus.empty      = is_empty;
    assign bus.cpu_rdata  = fwd_hit ? fwd_data : bus.mem_rdata;

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (addr_q[fwd_idx][AW-1:2] == bus.cpu_addr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (enq) begin
            addr_d[wr_ptr_q] = bus.cpu_addr;
            data_d[wr_ptr_q] = bus.cpu_wdata;
        end
        if (coal) begin
            data_d[tail] = bus.cpu_wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
        if (enq && !deq)      count_d = count_q + CW'(1);
        else if (!enq && deq) count_d = count_q - CW'(1);
        case (state_q)
            IDLE:    if (bus.flush) state_d = FLUSH;
            FLUSH:   if (is_empty)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entry contents carry no reset: validity is defined by count/pointers.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_write_buffer_if #(.AW(32), .DW(32)) bus ();
    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];        // reference contents, oldest first
    ent_t drained[$];   // writes observed on the memory port
    int   mode;         // 0 idle, 1 flushing, 2 done
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic wr, input logic fl, input logic [31:0] mrd);
        bus.cpu_we     = we;
        bus.cpu_addr   = addr;
        bus.cpu_wdata  = wd;
        bus.mem_wready = wr;
        bus.flush      = fl;
        bus.mem_rdata  = mrd;
    endtask

    function automatic logic [31:0] model_rdata();
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a[31:2] == bus.cpu_addr[31:2]) return mq[i].d;
        return bus.mem_rdata;
    endfunction

    // One clock: check every output against the model mid-cycle, then advance
    // the model by the rules for this cycle's inputs.
    task automatic step();
        bit hit_coal, exp_stall, do_deq;
        @(negedge clk);
        hit_coal = 1'b0;
`ifdef WBUF_COALESCE_EN
        hit_coal = bus.cpu_we && (mode != 1) && (mq.size() >= 2) &&
                   (mq[$].a[31:2] == bus.cpu_addr[31:2]);
`endif
        exp_stall = bus.cpu_we && ((mode == 1) || (mq.size() == DEPTH && !hit_coal));
        check("stall", 32'(bus.cpu_stall), 32'(exp_stall));
        check("rdata", bus.cpu_rdata, model_rdata());
        check("raddr", bus.mem_raddr, bus.cpu_addr);
        check("wvalid", 32'(bus.mem_wvalid), 32'(mq.size() != 0));
        check("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check("flush_done", 32'(bus.flush_done), 32'(mode == 2));
        if (mq.size() != 0) begin
            check("waddr", bus.mem_waddr, mq[0].a);
            check("wdata", bus.mem_wdata, mq[0].d);
        end
        if (bus.mem_wvalid && bus.mem_wready) drained.push_back({bus.mem_waddr, bus.mem_wdata});
        do_deq = (mq.size() != 0) && bus.mem_wready;
        case (mode)
            0: if (bus.flush) mode = 1;
            1: if (mq.size() == 0) mode = 2;
            default: mode = 0;
        endcase
        if (do_deq) void'(mq.pop_front());
        if (hit_coal) mq[$].d = bus.cpu_wdata;
        else if (bus.cpu_we && !exp_stall) mq.push_back({bus.cpu_addr, bus.cpu_wdata});
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20 && (mq.size() != 0 || mode != 0); i++) step();
        check("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        int zero_cyc;
        int fd_cyc;
        rst = 1'b1;
        mode = 0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, no traffic
        #1;
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_fdone", 32'(bus.flush_done), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'h12345678);
        step();

        // Forwarding of a buffered store; same-cycle store not forwarded
        drive(1'b1, 32'h10, 32'hAAAA0001, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("fwd_10", bus.cpu_rdata, 32'hAAAA0001);
        step();
        drive(1'b1, 32'h40, 32'h5, 1'b0, 1'b0, 32'hDEAD0000);
        #1;
        check("nofwd_same", bus.cpu_rdata, 32'hDEAD0000);
        step();
        drain_all();

        // Full buffer stalls the 5th store; no dequeue look-ahead
        drained.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b1, 32'h200, 32'h55, 1'b0, 1'b0, 32'h0);
        #1;
        check("full_stall", 32'(bus.cpu_stall), 32'd1);
        step();
        drive(1'b1, 32'h200, 32'h55, 1'b1, 1'b0, 32'h0);
        #1;
        check("stall_same_deq", 32'(bus.cpu_stall), 32'd1);
        check("head_addr", bus.mem_waddr, 32'h100);
        step();
        drive(1'b1, 32'h200, 32'h55, 1'b0, 1'b0, 32'h0);
        #1;
        check("stall_cleared", 32'(bus.cpu_stall), 32'd0);
        step();
        drain_all();
        check("full_first_out", drained[0].a, 32'h100);

        // Ordering and youngest-match forwarding
        drained.delete();
        drive(1'b1, 32'h20, 32'd1, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'h24, 32'd2, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'h20, 32'd3, 1'b0, 1'b0, 32'h0); step();
        drive(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'hFFFF0000);
        #1;
        check("fwd_youngest", bus.cpu_rdata, 32'd3);
        step();
        drain_all();
        check("order_n", 32'(drained.size()), 32'd3);
        if (drained.size() == 3) begin
            check("order0", drained[0], {32'h20, 32'd1});
            check("order1", drained[1], {32'h24, 32'd2});
            check("order2", drained[2], {32'h20, 32'd3});
        end

        // Flush: four writes, flush_done one cycle after the buffer empties
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'(i + 16), 1'b0, 1'b0, 32'h0);
            step();
        end
        drained.delete();
        drive(1'b1, 32'h400, 32'h77, 1'b1, 1'b1, 32'h0);
        step();
        drive(1'b1, 32'h400, 32'h77, 1'b1, 1'b0, 32'h0);
        #1;
        check("flush_stall", 32'(bus.cpu_stall), 32'd1);
        zero_cyc = -1;
        fd_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (bus.flush_done) begin
                fd_cyc = c;
                break;
            end
            if (bus.empty && zero_cyc < 0) zero_cyc = c;
            step();
        end
        check("flush_seen", 32'(fd_cyc >= 0), 32'd1);
        check("flush_timing", 32'(fd_cyc), 32'(zero_cyc + 1));
        check("flush_writes", 32'(drained.size()), 32'd4);
        step();
        check("flush_pulse", 32'(bus.flush_done), 32'd0);
        drain_all();

        // Reset mid-drain discards everything
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 32'(i + 32), 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        rst = 1'b1;
        #1;
        mq.delete();
        mode = 0;
        check("rstmid_empty", 32'(bus.empty), 32'd1);
        check("rstmid_wvalid", 32'(bus.mem_wvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drained.delete();
        repeat (3) step();
        check("rstmid_nowrite", 32'(drained.size()), 32'd0);

        // Same-word stores: coalesced only when the macro is defined
        drained.delete();
        drive(1'b1, 32'h30, 32'd1, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'h34, 32'd2, 1'b0, 1'b0, 32'h0); step();
        drive(1'b1, 32'h34, 32'd9, 1'b0, 1'b0, 32'h0); step();
        drain_all();
`ifdef WBUF_COALESCE_EN
        check("coal_n", 32'(drained.size()), 32'd2);
        if (drained.size() == 2) begin
            check("coal0", drained[0], {32'h30, 32'd1});
            check("coal1", drained[1], {32'h34, 32'd9});
        end
`else
        check("nocoal_n", 32'(drained.size()), 32'd3);
        if (drained.size() == 3) begin
            check("nocoal0", drained[0], {32'h30, 32'd1});
            check("nocoal1", drained[1], {32'h34, 32'd2});
            check("nocoal2", drained[2], {32'h34, 32'd9});
        end
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 32'h600 + 32'($urandom_range(0, 7)) * 4,
                  $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  $urandom);
            step();
        end
        drain_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
